// File: rtl/seq_det_pkg.sv
// Shared types and constant functions for the serial pattern detector.
// The KMP transition table is derived from these at elaboration time.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2
  } state_t;

  localparam int MIN_LEN = 2;
  localparam int MAX_LEN = 16;
  localparam int MAX_CNT_W = 32;

  function automatic int prog_w(int len);
    return $clog2(len + 1);
  endfunction

  // i-th pattern bit in arrival order (i=0 is the first bit expected)
  function automatic logic pat_bit(
    logic [15:0] pattern,
    int len,
    int i
  );
    return pattern[4'(len - 1 - i)];
  endfunction

  // Longest proper prefix that is also a suffix of the first k pattern bits
  function automatic int fail_len(
    logic [15:0] pattern,
    int len,
    int k
  );
    int best;
    logic ok;
    best = 0;
    for (int m = 1; m < k; m++) begin
      ok = 1'b1;
      for (int j = 0; j < m; j++) begin
        if (pat_bit(pattern, len, k - m + j) !=
            pat_bit(pattern, len, j))
          ok = 1'b0;
      end
      if (ok) best = m;
    end
    return best;
  endfunction

  // Longest prefix that is a suffix of (first k pattern bits, then b)
  function automatic int next_prog(
    logic [15:0] pattern,
    int len,
    int k,
    logic b
  );
    int best;
    int pos;
    logic ok;
    logic sb;
    best = 0;
    for (int m = 1; m <= k + 1; m++) begin
      if (m <= len) begin
        ok = 1'b1;
        for (int j = 0; j < m; j++) begin
          pos = k + 1 - m + j;
          sb = (pos == k) ? b : pat_bit(pattern, len, pos);
          if (sb != pat_bit(pattern, len, j))
            ok = 1'b0;
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating hit counter with a sticky flag raised on reaching all-ones.
// Synchronous clear has priority over increment.
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] ONES = '1;

  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != ONES)) begin
      count <= count_inc;
      if (count_inc == ONES)
        sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_fsm.sv
// Parametrised serial pattern detector (KMP automaton) with
// Mealy and Moore hit outputs and a saturating hit counter.
module seq_detector_fsm
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                PW      = prog_w(PAT_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             match_mealy,
  output logic             match_moore,
  output logic [PW-1:0]    progress,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  if (PAT_LEN < MIN_LEN || PAT_LEN > MAX_LEN) begin : g_bad_len
    $error("seq_detector_fsm: PAT_LEN must be 2..16");
  end

  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt
    $error("seq_detector_fsm: CNT_W must be 1..32");
  end

  localparam logic [15:0] PAT16 = 16'(PATTERN);
  localparam int R_INT =
    OVERLAP ? fail_len(PAT16, PAT_LEN, PAT_LEN) : 0;
  localparam logic [PW-1:0] RES  = PW'(R_INT);
  localparam logic [PW-1:0] FULL = PW'(PAT_LEN);
  localparam int TAB_N = 2 ** PW;

  // Entries at or above PAT_LEN are unreachable and tied to zero
  logic [PW-1:0] nxt_tab [TAB_N][2];

  for (genvar k = 0; k < TAB_N; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      if (k < PAT_LEN) begin : g_live
        assign nxt_tab[k][b] =
          PW'(next_prog(PAT16, PAT_LEN, k, 1'(b)));
      end else begin : g_dead
        assign nxt_tab[k][b] = '0;
      end
    end
  end

  state_t        state;
  state_t        state_d;
  logic [PW-1:0] prog;
  logic [PW-1:0] prog_d;
  logic [PW-1:0] nxt;
  logic          hit;

  assign nxt = nxt_tab[prog][in_bit];
  assign hit = reset && in_valid && !clear && (nxt == FULL);

  always_comb begin
    state_d = state;
    prog_d  = prog;
    if (clear) begin
      state_d = S_IDLE;
      prog_d  = '0;
    end else if (in_valid) begin
      if (hit) begin
        state_d = S_HIT;
        prog_d  = RES;
      end else begin
        state_d = (nxt == '0) ? S_IDLE : S_RUN;
        prog_d  = nxt;
      end
    end else if (state == S_HIT) begin
      state_d = (RES == '0) ? S_IDLE : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      prog  <= '0;
    end else begin
      state <= state_d;
      prog  <= prog_d;
    end
  end

  assign match_mealy = hit;
  assign match_moore = (state == S_HIT);
  assign progress    = prog;

  seq_det_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .inc  (hit),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule
